div_issue_ctrl: RTL and testbench

- EX-stage initiator for the iterative divider.
- Latches DIV/DIVU operands, drives the divider's permit/operand/sign inputs, and holds the pipeline stalled until finish_div is seen.
- Captures the divider's hi/lo outputs, holds them until EX advances, then issues a single HI/LO write.
- Handles pipeline flush mid-operation and a watchdog timeout.

---
 rtl/div_issue_ctrl_pkg.sv | 17 +
 rtl/div_issue_ctrl.sv | 103 ++++++++++
 tb/tb_div_issue_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the EX-stage divider initiator.
package div_issue_ctrl_pkg;

  // Control states of the divide issue sequence.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } div_state_t;

  // Divider latency in cycles; must track the divider's CYCLE parameter.
  localparam logic [4:0]  DIV_CYCLE_DEFAULT = 5'd10;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage : div_issue_ctrl_pkg

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the iterative divider: latches DIV/DIVU operands,
// keeps the divider permitted and the pipeline stalled until finish_div,
// holds the hi/lo result until EX advances, and aborts on flush or watchdog.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter logic [4:0] DIV_CYCLE     = DIV_CYCLE_DEFAULT,
  parameter logic [4:0] TIMEOUT_SLACK = 5'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [31:0] div_op1,
  input  logic [31:0] div_op2,
  input  logic        ex_advance,
  input  logic        flush,
  output logic        permit_div,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic        mult_sign,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic        finish_div,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        div_timeout
);

  // Last BUSY count value before the watchdog gives up on the divider.
  localparam logic [4:0] WAIT_LAST = DIV_CYCLE + TIMEOUT_SLACK - 5'd1;

  div_state_t state;
  logic [4:0] wait_cnt;

  // Sequencer: state, operand latches, result capture, watchdog counter.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      src1        <= ZERO_WORD;
      src2        <= ZERO_WORD;
      mult_sign   <= 1'b0;
      hi_wdata    <= ZERO_WORD;
      lo_wdata    <= ZERO_WORD;
      div_timeout <= 1'b0;
    end else begin
      div_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (div_req && !flush) begin
            src1      <= div_op1;
            src2      <= div_op2;
            mult_sign <= div_signed;
            wait_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt + 5'd1;
          // Flush wins over a same-cycle finish: the result is discarded.
          if (flush) begin
            state <= ABORT;
          end else if (finish_div) begin
            hi_wdata <= hi_in;
            lo_wdata <= lo_in;
            state    <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= ABORT;
            div_timeout <= 1'b1;
          end
        end
        DONE: begin
          // Wait for EX to move on so a held div_req does not relaunch.
          if (ex_advance || flush) begin
            state <= IDLE;
          end
        end
        ABORT: begin
          // One cycle with permit low lets the divider clear its counter.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Divider permit is simply "operation in flight".
  assign permit_div = (state == BUSY);

  // Stall starts in the request cycle itself; gated by reset so the
  // pipeline is released immediately when reset is asserted.
  assign stall_req = rst &&
                     ((state == BUSY) || ((state == IDLE) && div_req && !flush));

  // Single HI/LO write on the cycle the finished instruction leaves EX.
  assign hilo_we = (state == DONE) && ex_advance && !flush;

endmodule : div_issue_ctrl

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl: the bench plays the divider, driving
// finish_div and hand-computed hi/lo results at the expected cycle.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        ex_advance;
  logic        flush;
  logic        permit_div;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        mult_sign;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        finish_div;
  logic        stall_req;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        div_timeout;

  int vectors = 0;
  int errors  = 0;

  div_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .div_req    (div_req),
    .div_signed (div_signed),
    .div_op1    (div_op1),
    .div_op2    (div_op2),
    .ex_advance (ex_advance),
    .flush      (flush),
    .permit_div (permit_div),
    .src1       (src1),
    .src2       (src2),
    .mult_sign  (mult_sign),
    .hi_in      (hi_in),
    .lo_in      (lo_in),
    .finish_div (finish_div),
    .stall_req  (stall_req),
    .hilo_we    (hilo_we),
    .hi_wdata   (hi_wdata),
    .lo_wdata   (lo_wdata),
    .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE (cycle t) and check the same-cycle stall.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    div_req    = 1'b1;
    div_signed = sgn;
    div_op1    = a;
    div_op2    = b;
    flush      = 1'b0;
    ex_advance = 1'b0;
    #1;
    check("launch_stall", stall_req, 1);
    check("launch_permit", permit_div, 0);
    cyc();
    // EX operand bus wanders; the latched copies must not follow it.
    div_op1    = ~a;
    div_op2    = ~b;
    div_signed = ~sgn;
  endtask

  // n BUSY cycles; optionally the divider finishes on the last one.
  task automatic run_busy(input int n, input bit fin, input logic [31:0] hi, input logic [31:0] lo,
                          input logic [31:0] ea, input logic [31:0] eb, input logic esgn);
    for (int i = 1; i <= n; i++) begin
      if (fin && i == n) begin
        finish_div = 1'b1;
        hi_in      = hi;
        lo_in      = lo;
      end
      #1;
      check("busy_permit", permit_div, 1);
      check("busy_stall", stall_req, 1);
      check("busy_src1", src1, ea);
      check("busy_src2", src2, eb);
      check("busy_sign", mult_sign, esgn);
      check("busy_timeout", div_timeout, 0);
      check("busy_hilo_we", hilo_we, 0);
      cyc();
      finish_div = 1'b0;
      hi_in      = 32'hDEAD_BEEF;
      lo_in      = 32'hBAAD_F00D;
    end
  endtask

  // One DONE cycle with the given ex_advance.
  task automatic check_done(input logic [31:0] ehi, input logic [31:0] elo, input logic adv);
    ex_advance = adv;
    #1;
    check("done_permit", permit_div, 0);
    check("done_stall", stall_req, 0);
    check("done_hilo_we", hilo_we, adv);
    check("done_hi", hi_wdata, ehi);
    check("done_lo", lo_wdata, elo);
    cyc();
  endtask

  // Quiet IDLE cycle after an instruction has left.
  task automatic check_idle();
    div_req    = 1'b0;
    ex_advance = 1'b0;
    flush      = 1'b0;
    #1;
    check("idle_permit", permit_div, 0);
    check("idle_stall", stall_req, 0);
    check("idle_hilo_we", hilo_we, 0);
    check("idle_timeout", div_timeout, 0);
    cyc();
  endtask

  initial begin
    rst        = 1'b0;
    div_req    = 1'b0;
    div_signed = 1'b0;
    div_op1    = '0;
    div_op2    = '0;
    ex_advance = 1'b0;
    flush      = 1'b0;
    hi_in      = '0;
    lo_in      = '0;
    finish_div = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_permit", permit_div, 0);
    check("rst_stall", stall_req, 0);
    check("rst_hilo_we", hilo_we, 0);
    check("rst_src1", src1, 0);
    check("rst_hi", hi_wdata, 0);
    check("rst_timeout", div_timeout, 0);
    rst = 1'b1;
    cyc();

    // DIVU 100/7: quotient 14, remainder 2; permit t+1..t+11, write at t+12.
    launch(32'd100, 32'd7, 1'b0);
    run_busy(11, 1'b1, 32'd2, 32'd14, 32'd100, 32'd7, 1'b0);
    check_done(32'd2, 32'd14, 1'b1);
    check_idle();

    // DIV -7/2: quotient -3, remainder -1.
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_busy(11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check_done(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    check_idle();

    // DIVU 0x55/0 (divide by zero) held in DONE for 3 cycles with div_req
    // still high; divider's raw result is written unchanged, once.
    launch(32'h55, 32'h0, 1'b0);
    run_busy(11, 1'b1, 32'h55, 32'hFFFF_FFFF, 32'h55, 32'h0, 1'b0);
    check_done(32'h55, 32'hFFFF_FFFF, 1'b0);
    check_done(32'h55, 32'hFFFF_FFFF, 1'b0);
    check_done(32'h55, 32'hFFFF_FFFF, 1'b0);
    check_done(32'h55, 32'hFFFF_FFFF, 1'b1);
    check_idle();

    // Flush at t+5: ABORT at t+6 (div_req ignored), IDLE at t+7.
    launch(32'd40, 32'd8, 1'b0);
    run_busy(4, 1'b0, 32'd0, 32'd0, 32'd40, 32'd8, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_busy_permit", permit_div, 1);
    cyc();
    flush = 1'b0;
    #1;
    check("abort_permit", permit_div, 0);
    check("abort_stall", stall_req, 0);
    check("abort_hilo_we", hilo_we, 0);
    check("abort_timeout", div_timeout, 0);
    cyc();
    check_idle();

    // Flush coincident with finish_div: no capture, no write.
    launch(32'h20, 32'd4, 1'b0);
    run_busy(10, 1'b0, 32'd0, 32'd0, 32'h20, 32'd4, 1'b0);
    flush      = 1'b1;
    finish_div = 1'b1;
    hi_in      = 32'h1111;
    lo_in      = 32'h2222;
    #1;
    check("flush_fin_permit", permit_div, 1);
    cyc();
    flush      = 1'b0;
    finish_div = 1'b0;
    div_req    = 1'b0;
    #1;
    check("flush_fin_permit_ab", permit_div, 0);
    check("flush_fin_hilo_we", hilo_we, 0);
    check("flush_fin_timeout", div_timeout, 0);
    check("flush_fin_hi_kept", hi_wdata, 32'h55);
    check("flush_fin_lo_kept", lo_wdata, 32'hFFFF_FFFF);
    cyc();
    check_idle();

    // div_req together with flush in IDLE: no launch.
    div_req = 1'b1;
    flush   = 1'b1;
    #1;
    check("req_flush_stall", stall_req, 0);
    cyc();
    flush = 1'b0;
    div_req = 1'b0;
    #1;
    check("req_flush_permit", permit_div, 0);
    cyc();

    // Watchdog: finish_div never rises; 14 BUSY cycles, then one ABORT.
    launch(32'd1, 32'd1, 1'b0);
    run_busy(14, 1'b0, 32'd0, 32'd0, 32'd1, 32'd1, 1'b0);
    div_req = 1'b0;
    #1;
    check("wd_timeout", div_timeout, 1);
    check("wd_permit", permit_div, 0);
    check("wd_stall", stall_req, 0);
    check("wd_hilo_we", hilo_we, 0);
    cyc();
    check_idle();

    // Asynchronous reset mid-BUSY, then DIVU 9/3 from scratch.
    launch(32'd9, 32'd3, 1'b0);
    run_busy(3, 1'b0, 32'd0, 32'd0, 32'd9, 32'd3, 1'b0);
    rst = 1'b0;
    #1;
    check("arst_permit", permit_div, 0);
    check("arst_stall", stall_req, 0);
    check("arst_src1", src1, 0);
    check("arst_src2", src2, 0);
    check("arst_sign", mult_sign, 0);
    check("arst_hi", hi_wdata, 0);
    check("arst_lo", lo_wdata, 0);
    check("arst_hilo_we", hilo_we, 0);
    check("arst_timeout", div_timeout, 0);
    #2;
    rst     = 1'b1;
    div_req = 1'b0;
    cyc();
    launch(32'd9, 32'd3, 1'b0);
    run_busy(11, 1'b1, 32'd0, 32'd3, 32'd9, 32'd3, 1'b0);
    check_done(32'd0, 32'd3, 1'b1);
    check_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_div_issue_ctrl
